watch_set_ctrl: RTL and testbench

WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

---
 rtl/watch_set_ctrl.sv | 164 ++++++++++++++++
 tb/tb_watch_set_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/watch_set_ctrl.sv
// Set-mode controller for the watch display: steps through hour/min/sec fields,
// turns up/down buttons into inc/dec pulses with auto-repeat, and blinks the field.
module watch_set_ctrl #(
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int BLINK_HALF   = 25_000_000,
  parameter int TIMEOUT      = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       watch_sel,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       set_mode,
  output logic [1:0] sel,
  output logic       o_inc,
  output logic       o_dec,
  output logic       o_blink
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam int BLK_W   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [RPT_W-1:0] DELAY_LIM = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LIM  = RPT_W'(REPEAT_RATE - 1);
  localparam logic [RPT_W-1:0] RPT_SAT   = '1;
  localparam logic [BLK_W-1:0] BLINK_LIM = BLK_W'(BLINK_HALF - 1);
  localparam logic [TO_W-1:0]  TO_LIM    = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t state, state_n;

  logic             up_q, down_q, hist_valid;
  logic             armed_up, armed_down, repeating;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_lim;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_q;
  logic [TO_W-1:0]  to_cnt;

  logic in_set, to_expire, state_change;
  logic up_edge, down_edge, conflict, accept, held_armed, rpt_fire;

  // hist_valid keeps a button held across reset release from looking like a press
  assign in_set       = (state != IDLE);
  assign to_expire    = (to_cnt == TO_LIM);
  assign up_edge      = hist_valid & btn_up & ~up_q;
  assign down_edge    = hist_valid & btn_down & ~down_q;
  assign conflict     = btn_up & btn_down;
  assign state_change = (state_n != state);
  assign accept       = in_set & ~state_change & ~conflict;
  assign held_armed   = (armed_up & btn_up) | (armed_down & btn_down);
  assign rpt_lim      = repeating ? RATE_LIM : DELAY_LIM;
  assign rpt_fire     = held_armed & (rpt_cnt >= rpt_lim) & ~o_inc & ~o_dec;

  assign set_mode = in_set;
  assign sel      = state;
  assign o_blink  = ~in_set | btn_up | btn_down | blink_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Leaving set mode (deselect or timeout) outranks a mode press
  always_comb begin
    state_n = state;
    if (in_set && (!watch_sel || to_expire)) begin
      state_n = IDLE;
    end else if (btn_mode) begin
      case (state)
        IDLE:     state_n = watch_sel ? SET_HOUR : IDLE;
        SET_HOUR: state_n = SET_MIN;
        SET_MIN:  state_n = SET_SEC;
        SET_SEC:  state_n = IDLE;
        default:  state_n = IDLE;
      endcase
    end
  end

  // A press arms its direction; only an armed, still-held button auto-repeats
  always_ff @(posedge clk) begin
    if (rst) begin
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      hist_valid <= 1'b0;
      armed_up   <= 1'b0;
      armed_down <= 1'b0;
      repeating  <= 1'b0;
      rpt_cnt    <= '0;
      o_inc      <= 1'b0;
      o_dec      <= 1'b0;
    end else begin
      up_q       <= btn_up;
      down_q     <= btn_down;
      hist_valid <= 1'b1;
      o_inc      <= 1'b0;
      o_dec      <= 1'b0;
      if (!accept) begin
        armed_up   <= 1'b0;
        armed_down <= 1'b0;
        repeating  <= 1'b0;
        rpt_cnt    <= '0;
      end else if (up_edge) begin
        armed_up   <= 1'b1;
        armed_down <= 1'b0;
        repeating  <= 1'b0;
        rpt_cnt    <= '0;
        o_inc      <= 1'b1;
      end else if (down_edge) begin
        armed_up   <= 1'b0;
        armed_down <= 1'b1;
        repeating  <= 1'b0;
        rpt_cnt    <= '0;
        o_dec      <= 1'b1;
      end else if (held_armed) begin
        if (rpt_fire) begin
          o_inc     <= armed_up;
          o_dec     <= armed_down;
          repeating <= 1'b1;
          rpt_cnt   <= '0;
        end else if (rpt_cnt != RPT_SAT) begin
          rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
      end else begin
        armed_up   <= 1'b0;
        armed_down <= 1'b0;
        repeating  <= 1'b0;
        rpt_cnt    <= '0;
      end
    end
  end

  // Blink phase restarts visible on every field entry
  always_ff @(posedge clk) begin
    if (rst || state_change || !in_set) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (blink_cnt >= BLINK_LIM) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + BLK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_change || !in_set || up_edge || down_edge || btn_up || btn_down) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LIM) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Scoreboard bench for watch_set_ctrl: a timestamp-based reference model predicts
// each cycle's outputs, a monitor process pops and compares them.
module tb_watch_set_ctrl;

  localparam int RD = 8;
  localparam int RR = 4;
  localparam int BH = 3;
  localparam int TO = 20;

  logic       clk, rst, watch_sel, btn_mode, btn_up, btn_down;
  logic       set_mode, o_inc, o_dec, o_blink;
  logic [1:0] sel;

  watch_set_ctrl #(
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .BLINK_HALF  (BH),
    .TIMEOUT     (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .watch_sel(watch_sel),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .set_mode (set_mode),
    .sel      (sel),
    .o_inc    (o_inc),
    .o_dec    (o_dec),
    .o_blink  (o_blink)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic       set_mode;
    logic       inc;
    logic       dec;
    logic       blink;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   seen_inc = 0;

  // Reference model: field index plus timestamps of entry, last activity and the live press
  int   cyc = 0;
  bit   m_valid = 0;
  int   m_field = 0;
  bit   m_inc = 0, m_dec = 0;
  bit   m_prev_up = 0, m_prev_down = 0, m_hist = 0;
  int   m_live = 0;
  int   m_press_t = 0, m_zero_t = 0, m_entry_t = 0;

  task automatic applyStimulus(input logic r, input logic ws, input logic md,
                               input logic u, input logic d, input int n = 1);
    exp_t e;
    bit   pu, pd, expired, ch;
    int   nf, k;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r; watch_sel = ws; btn_mode = md; btn_up = u; btn_down = d;
      if (m_valid) begin
        e.cyc      = cyc;
        e.sel      = 2'(m_field);
        e.set_mode = (m_field != 0);
        e.inc      = m_inc;
        e.dec      = m_dec;
        e.blink    = (m_field == 0) || u || d || ((((cyc - m_entry_t) / BH) % 2) == 0);
        exp_q.push_back(e);
      end
      if (r) begin
        m_valid = 1; m_field = 0; m_inc = 0; m_dec = 0;
        m_prev_up = 0; m_prev_down = 0; m_hist = 0; m_live = 0;
        m_zero_t = cyc + 1; m_entry_t = cyc + 1;
      end else if (m_valid) begin
        pu = m_hist && u && !m_prev_up;
        pd = m_hist && d && !m_prev_down;
        expired = (m_field != 0) && ((cyc - m_zero_t) == TO - 1);
        nf = m_field;
        if (m_field != 0 && (!ws || expired)) nf = 0;
        else if (md) nf = (m_field == 0) ? (ws ? 1 : 0) : ((m_field + 1) % 4);
        ch = (nf != m_field);
        m_inc = 0; m_dec = 0;
        if (m_field == 0 || ch || (u && d)) begin
          m_live = 0;
        end else if (pu) begin
          m_live = 1; m_press_t = cyc; m_inc = 1;
        end else if (pd) begin
          m_live = 2; m_press_t = cyc; m_dec = 1;
        end else if ((m_live == 1 && u) || (m_live == 2 && d)) begin
          k = cyc - m_press_t;
          if (k == RD || (k > RD && ((k - RD) % RR) == 0)) begin
            if (m_live == 1) m_inc = 1;
            else             m_dec = 1;
          end
        end else begin
          m_live = 0;
        end
        if (ch || m_field == 0 || u || d) m_zero_t = cyc + 1;
        if (ch) m_entry_t = cyc + 1;
        m_prev_up = u; m_prev_down = d; m_hist = 1;
        m_field = nf;
      end
      cyc++;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (sel !== e.sel || set_mode !== e.set_mode || o_inc !== e.inc ||
        o_dec !== e.dec || o_blink !== e.blink) begin
      bad++;
      $display("[TB] FAIL outputs cyc=%0d got sel=%0d mode=%b inc=%b dec=%b blink=%b, want sel=%0d mode=%b inc=%b dec=%b blink=%b",
               e.cyc, sel, set_mode, o_inc, o_dec, o_blink,
               e.sel, e.set_mode, e.inc, e.dec, e.blink);
    end
  endtask

  // Monitor samples mid-cycle, after the stimulus has settled for that cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (o_inc === 1'b1) seen_inc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int  base;
    bit  bu, bd;
    logic ws, md, r;
    rst = 1'b1; watch_sel = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;

    applyStimulus(1, 1, 0, 0, 0, 2);
    applyStimulus(0, 1, 0, 0, 0, 2);

    // Four mode presses walk hour, min, sec, back to idle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 1, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 2);
    end

    // Held up in SET_MIN: pulses at P+1, P+9, P+13, P+17
    applyStimulus(0, 1, 1, 0, 0); applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0); applyStimulus(0, 1, 0, 0, 0, 2);
    base = seen_inc;
    applyStimulus(0, 1, 0, 1, 0, 20);
    applyStimulus(0, 1, 0, 0, 0, 3);
    total++;
    if (seen_inc - base != 4) begin
      bad++;
      $display("[TB] FAIL repeat_count got %0d want 4", seen_inc - base);
    end

    // To SET_HOUR, then both buttons together
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
    end
    applyStimulus(0, 1, 0, 1, 1, 10);
    applyStimulus(0, 1, 0, 0, 0, 2);
    applyStimulus(0, 1, 0, 1, 0, 3);
    applyStimulus(0, 1, 0, 0, 0, 2);
    applyStimulus(0, 1, 0, 0, 1, 2);
    applyStimulus(0, 1, 0, 0, 0, 2);

    // SET_SEC idle blink and timeout, restarted by a press
    applyStimulus(0, 1, 1, 0, 0); applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 14);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 25);

    // Deselect together with mode in SET_MIN
    applyStimulus(0, 1, 1, 0, 0); applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0); applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2);
    applyStimulus(0, 1, 0, 0, 0);

    // Mode together with a press edge, then a held button across the change
    applyStimulus(0, 1, 1, 0, 0); applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 1, 0, 1, 0, 12);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);

    // Reset during auto-repeat with the button still held
    applyStimulus(0, 1, 0, 1, 0, 14);
    applyStimulus(1, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 0, 4);
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 1, 0, 1, 0, 4);
    applyStimulus(0, 1, 0, 0, 0, 2);

    // Randomised traffic
    bu = 0; bd = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) bu = !bu;
      if ($urandom_range(0, 14) == 0) bd = !bd;
      ws = ($urandom_range(0, 39) != 0);
      md = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 399) == 0);
      applyStimulus(r, ws, md, bu, bd);
    end

    applyStimulus(0, 1, 0, 0, 0, 3);
    @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
